sample_ctrl: RTL and testbench

Sequencing controller for the sample-processing datapath. It accepts new-sample notifications from the input source and steps the datapath through shift, load, clear and NUM_TAPS multiply-accumulate operations. It emits one `cnt_up` pulse per cleanly processed sample to the downstream sample counter, and turns that counter's `one_k_samples` flag into a single-cycle batch-complete pulse. Arithmetic overflow reported by the datapath aborts the sample into an error state.

---
 rtl/sample_ctrl.sv | 170 +++++++++++++++++
 tb/tb_sample_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/sample_ctrl.sv
// sample_ctrl: sequencing controller for the sample-processing datapath.
// Detects new-sample edges, steps the datapath through SHIFT, LOAD, CLEAR and
// NUM_TAPS MAC operations, then issues cnt_up. Datapath overflow aborts the
// sample into ERROR. A one-deep pending flag absorbs an edge that arrives while
// busy. The rising edge of one_k_samples becomes a single-cycle batch_done.
module sample_ctrl #(
  parameter int NUM_TAPS = 4,
  parameter int TW       = $clog2(NUM_TAPS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          data_ready,
  input  logic          overflow,
  input  logic          one_k_samples,
  output logic          cnt_up,
  output logic          modwait,
  output logic [2:0]    op,
  output logic [TW-1:0] tap_sel,
  output logic          err,
  output logic          overrun,
  output logic          batch_done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHIFT = 3'd1,
    S_LOAD  = 3'd2,
    S_CLEAR = 3'd3,
    S_MAC   = 3'd4,
    S_CHECK = 3'd5,
    S_DONE  = 3'd6,
    S_ERROR = 3'd7
  } state_t;

  localparam logic [2:0]    OP_NOP   = 3'd0;
  localparam logic [2:0]    OP_LOAD  = 3'd1;
  localparam logic [2:0]    OP_SHIFT = 3'd2;
  localparam logic [2:0]    OP_MAC   = 3'd3;
  localparam logic [2:0]    OP_CLEAR = 3'd4;
  localparam logic [TW-1:0] LAST_TAP = TW'(NUM_TAPS - 1);
  localparam logic [TW-1:0] TAP_ONE  = TW'(1);

  state_t        state_q, state_d;
  logic          dr_q;
  logic          pending_q, pending_d;
  logic [TW-1:0] tap_q, tap_d;
  logic          ok_q, ok_q2;
  logic          batch_done_q;
  logic          start_edge;
  logic          busy;

  // A new sample is a rising edge of the source level signal.
  assign start_edge = data_ready & ~dr_q;

  // Busy means a sample is in flight; IDLE and ERROR can accept a new one.
  assign busy = (state_q != S_IDLE) && (state_q != S_ERROR);

  // Next-state and tap counter: walk the fixed op sequence, abort on overflow.
  always_comb begin
    state_d = state_q;
    tap_d   = '0;
    case (state_q)
      S_IDLE, S_ERROR: begin
        if (start_edge || pending_q) begin
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: state_d = S_LOAD;
      S_LOAD:  state_d = S_CLEAR;
      S_CLEAR: begin
        tap_d   = '0;
        state_d = S_MAC;
      end
      S_MAC: begin
        tap_d = tap_q + TAP_ONE;
        // overflow lags the op by one cycle, so the first MAC sees CLEAR's flag
        if (overflow && (tap_q != '0)) begin
          state_d = S_ERROR;
        end else if (tap_q == LAST_TAP) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        // flag here belongs to the last MAC
        if (overflow) begin
          state_d = S_ERROR;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Pending flag: remember one edge while busy; a start consumes it, and an
  // edge coinciding with that consume re-arms it.
  always_comb begin
    pending_d = pending_q;
    if (!busy) begin
      pending_d = start_edge & pending_q;
    end else if (start_edge) begin
      pending_d = 1'b1;
    end
  end

  // An edge arriving while busy with the pending slot already full is lost.
  assign overrun = busy & start_edge & pending_q;

  // Moore output decode from the state register.
  always_comb begin
    op      = OP_NOP;
    tap_sel = '0;
    cnt_up  = 1'b0;
    err     = 1'b0;
    modwait = busy;
    case (state_q)
      S_SHIFT: op = OP_SHIFT;
      S_LOAD:  op = OP_LOAD;
      S_CLEAR: op = OP_CLEAR;
      S_MAC: begin
        op      = OP_MAC;
        tap_sel = tap_q;
      end
      S_DONE:  cnt_up = 1'b1;
      S_ERROR: err = 1'b1;
      default: op = OP_NOP;
    endcase
  end

  // FSM state, tap counter and pending flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      tap_q     <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tap_q     <= tap_d;
      pending_q <= pending_d;
    end
  end

  // Edge-detect history; clearing it in reset makes a level held high
  // through reset release count as one sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      dr_q <= 1'b0;
    end else begin
      dr_q <= data_ready;
    end
  end

  // Batch pulse: rising edge of one_k_samples, registered so it lands two
  // cycles after the flag rises and lasts exactly one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      ok_q         <= 1'b0;
      ok_q2        <= 1'b0;
      batch_done_q <= 1'b0;
    end else begin
      ok_q         <= one_k_samples;
      ok_q2        <= ok_q;
      batch_done_q <= ok_q & ~ok_q2;
    end
  end

  assign batch_done = batch_done_q;

endmodule

// File: tb/tb_sample_ctrl.sv
// tb_sample_ctrl: cycle-by-cycle scenarios for sample_ctrl with NUM_TAPS = 4.
// Each scenario lays out per-cycle inputs and the expected output frame built
// from the documented sample timeline; frames are queued as each cycle is
// driven and compared on the following falling edge.
module tb_sample_ctrl;

  localparam int N    = 4;
  localparam int TW   = 2;
  localparam int MAXC = 48;

  logic          clk = 1'b0;
  logic          reset;
  logic          data_ready;
  logic          overflow;
  logic          one_k_samples;
  logic          cnt_up;
  logic          modwait;
  logic [2:0]    op;
  logic [TW-1:0] tap_sel;
  logic          err;
  logic          overrun;
  logic          batch_done;

  always #5 clk = ~clk;

  sample_ctrl #(.NUM_TAPS(N)) dut (
    .clk           (clk),
    .reset         (reset),
    .data_ready    (data_ready),
    .overflow      (overflow),
    .one_k_samples (one_k_samples),
    .cnt_up        (cnt_up),
    .modwait       (modwait),
    .op            (op),
    .tap_sel       (tap_sel),
    .err           (err),
    .overrun       (overrun),
    .batch_done    (batch_done)
  );

  typedef struct {
    string         tag;
    logic [2:0]    op;
    logic [TW-1:0] tap;
    logic          mw;
    logic          cnt;
    logic          err;
    logic          ovr;
    logic          bd;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_f;
  int   n_tests = 0;
  int   n_fail  = 0;

  // per-cycle stimulus and expected outputs for the current scenario
  logic          s_rst [MAXC];
  logic          s_dr  [MAXC];
  logic          s_ovf [MAXC];
  logic          s_ok  [MAXC];
  logic [2:0]    e_op  [MAXC];
  logic [TW-1:0] e_tap [MAXC];
  logic          e_mw  [MAXC];
  logic          e_cnt [MAXC];
  logic          e_err [MAXC];
  logic          e_ovr [MAXC];
  logic          e_bd  [MAXC];
  logic          e_chk [MAXC];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic exp_zero(input int c);
    e_op[c] = 3'd0; e_tap[c] = '0; e_mw[c] = 1'b0; e_cnt[c] = 1'b0;
    e_err[c] = 1'b0; e_ovr[c] = 1'b0; e_bd[c] = 1'b0;
  endtask

  // Cycle 0 carries reset and is not compared; every later cycle is.
  task automatic clear_scn();
    for (int c = 0; c < MAXC; c++) begin
      s_rst[c] = 1'b0; s_dr[c] = 1'b0; s_ovf[c] = 1'b0; s_ok[c] = 1'b0;
      exp_zero(c);
      e_chk[c] = 1'b1;
    end
    s_rst[0] = 1'b1;
    e_chk[0] = 1'b0;
  endtask

  task automatic set_dr(input int from, input int to, input logic v);
    for (int c = from; c <= to; c++) s_dr[c] = v;
  endtask

  // Edge accepted in IDLE/ERROR at cycle t: SHIFT t+1 .. DONE t+5+N.
  task automatic exp_sample(input int t);
    e_op[t+1] = 3'd2; e_mw[t+1] = 1'b1;
    e_op[t+2] = 3'd1; e_mw[t+2] = 1'b1;
    e_op[t+3] = 3'd4; e_mw[t+3] = 1'b1;
    for (int k = 0; k < N; k++) begin
      e_op[t+4+k] = 3'd3; e_tap[t+4+k] = TW'(k); e_mw[t+4+k] = 1'b1;
    end
    e_mw[t+4+N] = 1'b1;
    e_mw[t+5+N] = 1'b1; e_cnt[t+5+N] = 1'b1;
  endtask

  task automatic exp_err(input int from, input int to);
    for (int c = from; c <= to; c++) begin
      exp_zero(c);
      e_err[c] = 1'b1;
    end
  endtask

  task automatic exp_idle(input int from, input int to);
    for (int c = from; c <= to; c++) exp_zero(c);
  endtask

  task automatic run_scn(input string name, input int len);
    for (int c = 0; c < len; c++) begin
      @(posedge clk);
      #1;
      reset         = s_rst[c];
      data_ready    = s_dr[c];
      overflow      = s_ovf[c];
      one_k_samples = s_ok[c];
      if (e_chk[c]) begin
        exp_t f;
        f.tag = $sformatf("%s_c%0d", name, c);
        f.op  = e_op[c];  f.tap = e_tap[c]; f.mw  = e_mw[c];
        f.cnt = e_cnt[c]; f.err = e_err[c]; f.ovr = e_ovr[c]; f.bd = e_bd[c];
        sb_q.push_back(f);
      end
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_f = sb_q.pop_front();
      check({mon_f.tag, "_op"},      32'(op),         32'(mon_f.op));
      check({mon_f.tag, "_tap"},     32'(tap_sel),    32'(mon_f.tap));
      check({mon_f.tag, "_modwait"}, 32'(modwait),    32'(mon_f.mw));
      check({mon_f.tag, "_cnt_up"},  32'(cnt_up),     32'(mon_f.cnt));
      check({mon_f.tag, "_err"},     32'(err),        32'(mon_f.err));
      check({mon_f.tag, "_overrun"}, 32'(overrun),    32'(mon_f.ovr));
      check({mon_f.tag, "_batch"},   32'(batch_done), 32'(mon_f.bd));
    end
  end

  initial begin
    reset = 1'b1; data_ready = 1'b0; overflow = 1'b0; one_k_samples = 1'b0;

    // single sample, data_ready held high afterwards
    clear_scn();
    set_dr(5, 24, 1'b1);
    exp_sample(5);
    run_scn("single", 25);

    // edges at 5, 8 (pending) and 11 (dropped)
    clear_scn();
    set_dr(5, 6, 1'b1); set_dr(8, 9, 1'b1); set_dr(11, 39, 1'b1);
    exp_sample(5);
    exp_sample(15);
    e_ovr[11] = 1'b1;
    run_scn("pending", 40);

    // overflow in third MAC, then recovery on the next edge
    clear_scn();
    set_dr(5, 14, 1'b1); set_dr(17, 29, 1'b1);
    s_ovf[11] = 1'b1;
    exp_sample(5);
    exp_err(12, 17);
    exp_sample(17);
    run_scn("ovf_mac", 30);

    // overflow outside MAC and in the first MAC ignored; at CHECK aborts
    clear_scn();
    set_dr(5, 19, 1'b1);
    s_ovf[3] = 1'b1; s_ovf[7] = 1'b1; s_ovf[9] = 1'b1; s_ovf[13] = 1'b1;
    exp_sample(5);
    exp_err(14, 19);
    run_scn("ovf_check", 20);

    // batch pulse
    clear_scn();
    for (int c = 20; c <= 31; c++) s_ok[c] = 1'b1;
    e_bd[22] = 1'b1;
    run_scn("batch", 36);

    // data_ready high through reset release counts once
    clear_scn();
    set_dr(0, 13, 1'b1);
    exp_sample(1);
    run_scn("dr_thru_rst", 14);

    // reset during MAC tap 1 with a pending edge outstanding
    clear_scn();
    set_dr(5, 6, 1'b1); set_dr(8, 8, 1'b1);
    s_rst[10] = 1'b1;
    exp_sample(5);
    exp_idle(11, 21);
    run_scn("rst_mid", 22);

    // edge in CHECK sets pending; edge in IDLE with pending re-arms it
    clear_scn();
    set_dr(5, 11, 1'b1); set_dr(13, 13, 1'b1); set_dr(15, 39, 1'b1);
    exp_sample(5);
    exp_sample(15);
    exp_sample(25);
    run_scn("rearm", 40);

    // edge in the DONE cycle restarts two cycles later
    clear_scn();
    set_dr(5, 12, 1'b1); set_dr(14, 29, 1'b1);
    exp_sample(5);
    exp_sample(15);
    run_scn("edge_done", 30);

    repeat (2) @(posedge clk);
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
